// File: rtl/sevenseg_scan.sv
// sevenseg_scan -- four-digit multiplexed seven-segment driver (MM:SS display).
//
// The four BCD inputs are captured into a shadow register while upd is high.
// The display always scans the shadow copy, so the inputs cannot tear a frame.
// One digit is driven at a time. Each digit stays active for REFRESH_DIV
// clocks, and the scan order is 0,1,2,3. A free-running blink counter toggles a
// blink phase every BLINK_DIV clocks. While ADJ is high and the phase is 1,
// the digit pair chosen by SEL is blanked.
//
// Parameters:
//   REFRESH_DIV  clocks per digit slot (>= 2)
//   BLINK_DIV    clocks per blink-phase toggle (>= 2)
//
// Ports:
//   clk             system clock, rising edge
//   RESET           synchronous active-high reset
//   d3,d2,d1,d0     BCD digits (minutes tens .. seconds units)
//   upd             load strobe for the shadow digits
//   ADJ             adjust mode, enables blinking of the selected pair
//   SEL             pair select: 0 = seconds (d1:d0), 1 = minutes (d3:d2)
//   seg[6:0]        cathodes {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low, lit in the digit-2 slot
//   an[3:0]         anode enables, active-low, an[i] drives digit i
//
// Optional feature macro: SEVENSEG_LEADING_ZERO_BLANK_EN
//   When this macro is defined, digit 3 is blanked whenever the latched d3 is 0.
//
// Blanking gates only the anodes. seg and dp keep their decoded values, and
// with every anode off those values have no visible effect.

module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       upd,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

  logic [RW-1:0]     r_rcnt;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_dig;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [3:0]        r_an;

  logic [3:0]        w_cur;
  logic [6:0]        w_seg;
  logic              w_in_pair;
  logic              w_blank;
  logic [3:0]        w_an;

  // Decode the shadow digit selected by the current scan index.
  always_comb begin
    w_cur = r_dig[r_idx];
    case (w_cur)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h3F;  // non-BCD shows a dash
    endcase
  end

  // Digits 2/3 form the minutes pair and digits 0/1 form the seconds pair.
  // idx[1] tells the two pairs apart.
  assign w_in_pair = SEL ? r_idx[1] : ~r_idx[1];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  assign w_blank = (ADJ & r_phase & w_in_pair) |
                   ((r_idx == 2'd3) && (r_dig[3] == 4'd0));
`else
  assign w_blank = ADJ & r_phase & w_in_pair;
`endif

  assign w_an = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_rcnt  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_idx   <= 2'd0;
      r_dig   <= '0;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_an    <= 4'b1111;
    end else begin
      // Outputs reflect the scan index and shadow digits from before this edge.
      r_seg <= w_seg;
      r_an  <= w_an;
      r_dp  <= (r_idx != 2'd2);

      if (r_rcnt == R_MAX) begin
        r_rcnt <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_rcnt <= r_rcnt + 1'b1;
      end

      if (r_bcnt == B_MAX) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end

      if (upd) begin
        r_dig <= {d3, d2, d1, d0};
      end
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan with REFRESH_DIV=4 and BLINK_DIV=16.
// The reference model works from the number of clocks since reset:
//   slot index  = (n / REFRESH_DIV) % 4
//   blink phase = (n / BLINK_DIV) % 2
// It also keeps a plain array of the latched digits.
// Every cycle is compared against the model. Directed phases add literal
// expectations for the reset sequence, digit loading, dash decode and reset recovery.

module tb_sevenseg_scan;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk;
  logic       RESET;
  logic [3:0] d3, d2, d1, d0;
  logic       upd, ADJ, SEL;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  sevenseg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .RESET(RESET),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .upd(upd), .ADJ(ADJ), .SEL(SEL),
    .seg(seg), .dp(dp), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int         m_n;
  logic [3:0] m_dig [4];
  logic [6:0] seg_tab [16];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  int         exp_idx;
  int         exp_ph;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: predict from the model and the present inputs, advance, compare.
  task automatic cycle();
    logic blank;
    if (RESET) begin
      exp_an  = 4'b1111;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_idx = -1;
      exp_ph  = 0;
      m_n     = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    end else begin
      exp_idx = (m_n / R) % 4;
      exp_ph  = (m_n / B) % 2;
      blank   = ADJ && (exp_ph == 1) && (SEL ? (exp_idx >= 2) : (exp_idx < 2));
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (exp_idx == 3 && m_dig[3] == 4'd0) blank = 1'b1;
`endif
      exp_an  = blank ? 4'b1111 : 4'(~(4'b0001 << exp_idx));
      exp_seg = seg_tab[m_dig[exp_idx]];
      exp_dp  = (exp_idx == 2) ? 1'b0 : 1'b1;
      if (upd) begin
        m_dig[0] = d0; m_dig[1] = d1; m_dig[2] = d2; m_dig[3] = d3;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    check("an",  {4'h0, an},  {4'h0, exp_an});
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("dp",  {7'h0, dp},  {7'h0, exp_dp});
  endtask

  logic [3:0] an_pin [17];
  logic       found;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    an_pin  = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};
    m_n = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;

    RESET = 1'b1; upd = 1'b0; ADJ = 1'b0; SEL = 1'b0;
    d3 = 4'd7; d2 = 4'd7; d1 = 4'd7; d0 = 4'd7;
    #2;
    cycle(); cycle();
    check("rst_an_lit",  {4'h0, an},  8'h0F);
    check("rst_seg_lit", {1'b0, seg}, 8'h7F);

    // Reset followed by idle: check the literal scan sequence.
    RESET = 1'b0;
    for (int k = 0; k < 17; k++) begin
      cycle();
      check("idle_an_lit",  {4'h0, an},  {4'h0, an_pin[k]});
      check("idle_seg_lit", {1'b0, seg}, 8'h40);
      check("idle_dp_lit",  {7'h0, dp},  {7'h0, (an_pin[k] == 4'hB) ? 1'b0 : 1'b1});
    end

    // Load 1,2,3,4, then change the inputs with upd low.
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4; upd = 1'b1;
    cycle();
    upd = 1'b0; d3 = 4'd9; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (exp_idx == 0) check("ld_d0_lit", {1'b0, seg}, 8'h19);
      if (exp_idx == 3) check("ld_d3_lit", {1'b0, seg}, 8'h79);
    end

    // Latch the invalid value B into d1 and expect a dash.
    d3 = 4'd1; d2 = 4'd2; d1 = 4'hB; d0 = 4'd4; upd = 1'b1;
    cycle();
    upd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (exp_idx == 1) check("dash_lit", {1'b0, seg}, 8'h3F);
    end

    // Adjust the minutes pair across several blink phases, then release ADJ.
    ADJ = 1'b1; SEL = 1'b1;
    for (int k = 0; k < 48; k++) begin
      cycle();
      if (exp_ph == 1 && exp_idx >= 2) check("blink_off_lit", {4'h0, an}, 8'h0F);
      if (exp_idx == 0) check("blink_keep_lit", {4'h0, an}, 8'h0E);
    end
    ADJ = 1'b0;
    for (int k = 0; k < 20; k++) cycle();

    // Randomised traffic.
    for (int k = 0; k < 4000; k++) begin
      d3 = 4'($urandom_range(0, 15)); d2 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15)); d0 = 4'($urandom_range(0, 15));
      upd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) ADJ = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) SEL = 1'($urandom_range(0, 1));
      RESET = ($urandom_range(0, 399) == 0);
      cycle();
    end
    RESET = 1'b0; upd = 1'b0; ADJ = 1'b0;

    // Assert reset at idx 2 in the middle of a blink period.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (((m_n / R) % 4) == 2 && (m_n % B) != 0) found = 1'b1;
      else cycle();
    end
    check("find_idx2", {7'h0, found}, 8'h01);
    RESET = 1'b1;
    cycle();
    check("mid_rst_an_lit",  {4'h0, an},  8'h0F);
    check("mid_rst_seg_lit", {1'b0, seg}, 8'h7F);
    RESET = 1'b0;
    cycle();
    check("restart_an_lit",  {4'h0, an},  8'h0E);
    check("restart_seg_lit", {1'b0, seg}, 8'h40);
    check("restart_dp_lit",  {7'h0, dp},  8'h01);
    for (int k = 0; k < 20; k++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles each digit stays active before the scan advances (minimum 2).
REQ-002 Parameter BLINK_DIV, default 25000000, meaning clk cycles per blink-phase toggle (minimum 2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 d3, d2, d1, d0  input  4 each  BCD digits, d3 = minutes tens, d2 = minutes units, d1 = seconds tens, d0 = seconds units.
REQ-006 upd  input  1  load strobe; digits are captured while high.
REQ-007 ADJ  input  1  adjust mode; enables blinking of the selected digit pair.
REQ-008 SEL  input  1  pair select; 0 = seconds (d1:d0), 1 = minutes (d3:d2).
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 an  output  4  anode enables, active-low; an[i] drives digit i.

Function
REQ-012 Shadow register: four 4-bit latched digits; on any clk edge with upd=1 all four load from d3..d0; with upd=0 they hold.
REQ-013 Display always uses the latched digits; the d inputs never reach seg directly (no tearing mid-scan).
REQ-014 Refresh counter: counts 0 to REFRESH_DIV-1, then wraps to 0; the wrap advances the scan index.
REQ-015 Scan index: 2-bit, sequence 0,1,2,3,0, changes only on a refresh wrap.
REQ-016 seg, dp, an registered: 1 clk latency from the current scan index and latched digits.
REQ-017 an is one-hot-low, with an[idx]=0 and all other bits 1, unless the active digit is blanked; a blanked digit gives an=4'b1111.
REQ-018 Decode, with seg active-low as {g..a}: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-019 Invalid BCD values 10-15 decode to a dash, seg=7'h3F.
REQ-020 dp=0 only while idx=2 (minutes:seconds separator); otherwise dp=1.
REQ-021 Blink counter: free-runs 0 to BLINK_DIV-1 regardless of ADJ; each wrap toggles blink phase.
REQ-022 Blanking applies when ADJ=1 and blink phase=1 and the active digit belongs to the pair chosen by SEL.
REQ-023 ADJ/SEL changes take effect on the next registered output update; no counter is disturbed by them.
REQ-024 If upd=1 in the same cycle as a refresh wrap, the new digit output uses the newly loaded values one cycle later.

Reset
REQ-025 RESET=1 at a clk edge forces an=4'b1111, seg=7'h7F and dp=1.
REQ-026 The same reset forces the refresh counter, blink counter, blink phase, scan index and all latched digits to 0.
REQ-027 RESET has priority over upd and over counter wraps, including mid-scan and mid-blink.
REQ-028 On the first edge after RESET is deasserted, outputs drive digit 0 (an=4'b1110, seg=7'h40, dp=1).

Configuration
REQ-029 Macro SEVENSEG_LEADING_ZERO_BLANK_EN: when defined, digit 3 is blanked (an[3] stays 1) whenever the latched d3 is 0.
REQ-030 Without SEVENSEG_LEADING_ZERO_BLANK_EN, digit 3 is always shown, subject only to blink blanking.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-031 Reset then idle: an=1110 for 4 cycles, then 1101, 1011, 0111, 1110; seg=7'h40 throughout; dp=0 only while an=1011.
REQ-032 upd pulse with d3..d0=1,2,3,4: next scan of digit 0 gives seg=7'h19; digit 3 gives seg=7'h79; inputs changed while upd=0 leave seg unchanged.
REQ-033 Latch d1=4'hB: seg=7'h3F while an=1101.
REQ-034 ADJ=1, SEL=1: during blink phase 1, an=1111 in idx 2/3 slots while idx 0/1 display normally; ADJ=0 restores all digits on the next update.
REQ-035 RESET asserted at idx=2, mid-blink: next edge an=1111, seg=7'h7F; after release, scan restarts at an=1110.
REQ-036 SEVENSEG_LEADING_ZERO_BLANK_EN defined with d3=0: idx 3 slot shows an=1111; with d3=5 it shows an=0111, seg=7'h12.
